// File: rtl/secuenciador_cs_registros.sv
// rtl/secuenciador_cs_registros.sv - function code to register chip-select sequencer
// Group or single-field chip selects with break-before-make on every function change.
module secuenciador_cs_registros #(
    parameter int ANCHO_FUNC = 2,
    parameter int N_CAMPOS   = 10,
    parameter logic [(2**ANCHO_FUNC)*N_CAMPOS-1:0] MASCARAS =
        {10'b1110000000, 10'b0001111000, 10'b0000000111, 10'b0000000000},
    parameter int ANCHO_IDX  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ANCHO_FUNC-1:0] funcion_conf,
    input  logic                  modo_campo,
    input  logic                  boton_sig,
    input  logic                  boton_ant,
    output logic [N_CAMPOS-1:0]   cs_out,
    output logic [ANCHO_IDX-1:0]  campo_idx,
    output logic                  valido,
    output logic                  cambio
);

    typedef enum logic [1:0] {INACTIVO, CARGA, ACTIVO} estado_t;

    estado_t               estado_q, estado_d;
    logic [ANCHO_FUNC-1:0] func_q, func_d;
    logic [ANCHO_IDX-1:0]  ptr_q, ptr_d;
    logic [N_CAMPOS-1:0]   cs_q, cs_d;
    logic                  valido_q, valido_d;
    logic                  cambio_q, cambio_d;

    logic [N_CAMPOS-1:0]   mask;
    logic [N_CAMPOS-1:0]   onehot;
    logic [ANCHO_IDX-1:0]  idx_low, idx_high, idx_sig, idx_ant;
    logic                  hay_sig, hay_ant;
    logic                  cambio_func;

    assign cambio_func = (funcion_conf != func_q);

    always_comb begin
        mask = '0;
        for (int f = 0; f < (1 << ANCHO_FUNC); f++) begin
            if (func_q == ANCHO_FUNC'(f)) begin
                mask = MASCARAS[f*N_CAMPOS +: N_CAMPOS];
            end
        end
    end

    // Descending scan leaves the lowest hit, ascending scan the highest.
    always_comb begin
        idx_low  = '0;
        idx_high = '0;
        idx_sig  = '0;
        idx_ant  = '0;
        hay_sig  = 1'b0;
        hay_ant  = 1'b0;
        for (int i = N_CAMPOS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx_low = ANCHO_IDX'(i);
                if (ANCHO_IDX'(i) > ptr_q) begin
                    idx_sig = ANCHO_IDX'(i);
                    hay_sig = 1'b1;
                end
            end
        end
        for (int i = 0; i < N_CAMPOS; i++) begin
            if (mask[i]) begin
                idx_high = ANCHO_IDX'(i);
                if (ANCHO_IDX'(i) < ptr_q) begin
                    idx_ant = ANCHO_IDX'(i);
                    hay_ant = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= INACTIVO;
            func_q   <= '0;
            ptr_q    <= '0;
            cs_q     <= '0;
            valido_q <= 1'b0;
            cambio_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            func_q   <= func_d;
            ptr_q    <= ptr_d;
            cs_q     <= cs_d;
            valido_q <= valido_d;
            cambio_q <= cambio_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        if (cambio_func) begin
            estado_d = CARGA;
        end else begin
            case (estado_q)
                CARGA:    estado_d = (mask == '0) ? INACTIVO : ACTIVO;
                ACTIVO:   estado_d = ACTIVO;
                INACTIVO: estado_d = INACTIVO;
                default:  estado_d = INACTIVO;
            endcase
        end
    end

    always_comb begin
        func_d   = func_q;
        ptr_d    = ptr_q;
        cs_d     = cs_q;
        valido_d = valido_q;
        cambio_d = 1'b0;
        onehot   = '0;
        if (cambio_func) begin
            func_d   = funcion_conf;
            cs_d     = '0;
            valido_d = 1'b0;
            cambio_d = 1'b1;
        end else begin
            if (estado_q == CARGA && mask != '0) begin
                ptr_d = idx_low;
            end else if (estado_q == ACTIVO && boton_sig && !boton_ant) begin
                ptr_d = hay_sig ? idx_sig : idx_low;
            end else if (estado_q == ACTIVO && boton_ant && !boton_sig) begin
                ptr_d = hay_ant ? idx_ant : idx_high;
            end
            for (int i = 0; i < N_CAMPOS; i++) begin
                onehot[i] = (ptr_d == ANCHO_IDX'(i));
            end
            case (estado_q)
                CARGA, ACTIVO: begin
                    valido_d = (mask != '0);
                    cs_d     = (mask == '0) ? '0 : (modo_campo ? onehot : mask);
                end
                default: begin
                    valido_d = 1'b0;
                    cs_d     = '0;
                end
            endcase
        end
    end

    assign cs_out    = cs_q;
    assign campo_idx = ptr_q;
    assign valido    = valido_q;
    assign cambio    = cambio_q;

endmodule

// File: tb/tb_secuenciador_cs_registros.sv
// tb/tb_secuenciador_cs_registros.sv - self-checking bench for secuenciador_cs_registros
// Cycle model plus directed literal checks on the chip-select sequencer.
module tb_secuenciador_cs_registros;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] funcion_conf;
    logic       modo_campo;
    logic       boton_sig;
    logic       boton_ant;
    logic [9:0] cs_out;
    logic [3:0] campo_idx;
    logic       valido;
    logic       cambio;

    int checks = 0;
    int passes = 0;

    secuenciador_cs_registros dut (
        .clk          (clk),
        .reset        (reset),
        .funcion_conf (funcion_conf),
        .modo_campo   (modo_campo),
        .boton_sig    (boton_sig),
        .boton_ant    (boton_ant),
        .cs_out       (cs_out),
        .campo_idx    (campo_idx),
        .valido       (valido),
        .cambio       (cambio)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // Field masks of the legacy decode, written out by hand.
    function automatic logic [9:0] mask_of(input int f);
        case (f)
            1:       return 10'b0000000111;
            2:       return 10'b0001111000;
            3:       return 10'b1110000000;
            default: return 10'b0000000000;
        endcase
    endfunction

    function automatic int lowest(input logic [9:0] m);
        for (int i = 0; i < 10; i++) if (m[i]) return i;
        return 0;
    endfunction

    // Walk around the ring of 10 fields until a set bit is met.
    function automatic int step(input logic [9:0] m, input int p, input int dir);
        int q = p;
        for (int k = 0; k < 10; k++) begin
            q = (q + dir + 10) % 10;
            if (m[q]) return q;
        end
        return p;
    endfunction

    int         m_func = 0;
    int         m_ptr = 0;
    bit         m_load = 0;
    bit         m_on = 0;
    logic [9:0] exp_cs = '0;
    logic [3:0] exp_idx = '0;
    logic       exp_val = 0;
    logic       exp_cam = 0;

    always @(posedge clk) begin
        logic [9:0] msk;
        if (reset) begin
            m_func = 0; m_ptr = 0; m_load = 0; m_on = 0;
            exp_cs = '0; exp_val = 0; exp_cam = 0;
        end else if (int'(funcion_conf) != m_func) begin
            m_func = int'(funcion_conf);
            m_load = 1; m_on = 0;
            exp_cs = '0; exp_val = 0; exp_cam = 1;
        end else begin
            exp_cam = 0;
            msk = mask_of(m_func);
            if (m_load) begin
                m_load = 0;
                m_on = (msk != 0);
                if (m_on) m_ptr = lowest(msk);
            end else if (m_on && (boton_sig ^ boton_ant)) begin
                m_ptr = step(msk, m_ptr, boton_sig ? 1 : -1);
            end
            exp_cs  = m_on ? (modo_campo ? (10'b1 << m_ptr) : msk) : 10'b0;
            exp_val = m_on;
        end
        exp_idx = 4'(m_ptr);
    end

    always @(negedge clk) begin
        chk("model_cs_out", 32'(cs_out), 32'(exp_cs));
        chk("model_campo_idx", 32'(campo_idx), 32'(exp_idx));
        chk("model_valido", 32'(valido), 32'(exp_val));
        chk("model_cambio", 32'(cambio), 32'(exp_cam));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    logic [4:0] vec [0:15] = '{
        5'b11_0_1_0, 5'b11_0_0_0, 5'b11_0_1_0, 5'b11_0_0_0,
        5'b11_1_1_0, 5'b11_1_0_1, 5'b11_1_0_1, 5'b11_1_0_0,
        5'b01_1_0_0, 5'b01_1_0_0, 5'b01_1_0_1, 5'b01_1_1_0,
        5'b00_1_0_0, 5'b00_1_1_0, 5'b00_1_0_0, 5'b10_0_0_1
    };
    int exp_seq [4] = '{4, 5, 6, 3};

    initial begin
        reset = 1; funcion_conf = 0; modo_campo = 0; boton_sig = 0; boton_ant = 0;
        tick(); tick();
        chk("reset_cs", 32'(cs_out), 0);
        chk("reset_valido", 32'(valido), 0);
        reset = 0;

        boton_sig = 1; tick(); boton_sig = 0; tick();
        chk("idle_cs", 32'(cs_out), 0);
        chk("idle_idx", 32'(campo_idx), 0);
        chk("idle_cambio", 32'(cambio), 0);

        funcion_conf = 2'b10; tick();
        chk("chg_break_cs", 32'(cs_out), 0);
        chk("chg_cambio", 32'(cambio), 1);
        tick();
        chk("date_group_cs", 32'(cs_out), 32'(10'b0001111000));
        chk("date_valido", 32'(valido), 1);
        chk("date_idx", 32'(campo_idx), 3);

        modo_campo = 1; tick();
        chk("single_cs", 32'(cs_out), 32'(10'b0000001000));
        for (int k = 0; k < 4; k++) begin
            boton_sig = 1; tick(); boton_sig = 0;
            chk("sig_idx", 32'(campo_idx), 32'(exp_seq[k]));
            chk("sig_cs", 32'(cs_out), 32'(10'b1 << exp_seq[k]));
            tick();
        end
        boton_ant = 1; tick(); boton_ant = 0;
        chk("ant_wrap_idx", 32'(campo_idx), 6);
        tick();

        funcion_conf = 2'b01; tick(); tick();
        funcion_conf = 2'b11; boton_sig = 1; tick(); boton_sig = 0;
        chk("timer_break_cs", 32'(cs_out), 0);
        chk("timer_cambio", 32'(cambio), 1);
        tick();
        chk("timer_cs", 32'(cs_out), 32'(10'b0010000000));
        chk("timer_idx", 32'(campo_idx), 7);

        boton_sig = 1; boton_ant = 1; tick(); boton_sig = 0; boton_ant = 0;
        chk("both_idx", 32'(campo_idx), 7);
        chk("both_cs", 32'(cs_out), 32'(10'b0010000000));
        modo_campo = 0; tick();
        chk("group_back_cs", 32'(cs_out), 32'(10'b1110000000));
        chk("group_back_idx", 32'(campo_idx), 7);

        funcion_conf = 2'b10; tick();
        reset = 1; funcion_conf = 0; tick();
        chk("rst_carga_cs", 32'(cs_out), 0);
        chk("rst_carga_idx", 32'(campo_idx), 0);
        reset = 0; tick();

        funcion_conf = 2'b10; tick(); tick(); tick();
        reset = 1; funcion_conf = 0; tick();
        chk("rst_activo_cs", 32'(cs_out), 0);
        chk("rst_activo_valido", 32'(valido), 0);
        reset = 0; tick();
        funcion_conf = 2'b01; tick(); tick();
        chk("hour_cs", 32'(cs_out), 32'(10'b0000000111));

        funcion_conf = 2'b00; tick(); tick();
        chk("none_cs", 32'(cs_out), 0);
        chk("none_valido", 32'(valido), 0);

        for (int v = 0; v < 16; v++) begin
            {funcion_conf, modo_campo, boton_sig, boton_ant} = vec[v];
            tick();
        end
        boton_sig = 0; boton_ant = 0; tick(); tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
